// File: rtl/sdr_cmd_monitor.sv
// SDRAM command-bus monitor: decodes commands, tracks per-bank state,
// flags protocol violations and counts ACT/READ/WRITE traffic.
module sdr_cmd_monitor #(
  parameter int NUM_BANKS = 4,
  parameter int BA_W      = 2,
  parameter int ROW_W     = 13,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_resetn,
  input  logic                 sdr_cs_n,
  input  logic                 sdr_ras_n,
  input  logic                 sdr_cas_n,
  input  logic                 sdr_we_n,
  input  logic [BA_W-1:0]      sdr_ba,
  input  logic [ROW_W-1:0]     sdr_addr,
  input  logic                 clr_cnt,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_code,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 err_valid,
  output logic [2:0]           err_code,
  output logic [BA_W-1:0]      err_bank,
  output logic [CNT_W-1:0]     act_cnt,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic [CNT_W-1:0]     wr_cnt
);

  localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;
  localparam logic [2:0] C_MRS = 3'd6;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_OPEN = 3'd1;
  localparam logic [2:0] E_ACC  = 3'd2;
  localparam logic [2:0] E_TRCD = 3'd3;
  localparam logic [2:0] E_TRP  = 3'd4;
  localparam logic [2:0] E_REF  = 3'd5;

  typedef enum logic [1:0] {
    B_IDLE, B_ACTV, B_OPEN, B_PREC
  } bank_st_t;

  bank_st_t            st_q   [NUM_BANKS];
  bank_st_t            st_d   [NUM_BANKS];
  logic [TW-1:0]       tmr_q  [NUM_BANKS];
  logic [TW-1:0]       tmr_d  [NUM_BANKS];
  logic [NUM_BANKS-1:0] open_d;
  logic [2:0]          cmd_d;
  logic [2:0]          err_d;
  logic [BA_W-1:0]     ebank_d;
  bank_st_t            sel_st;
  logic                any_busy;

  always_comb begin
    cmd_d = C_NOP;
    if (!sdr_cs_n) begin
      case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
        3'b011:  cmd_d = C_ACT;
        3'b101:  cmd_d = C_RD;
        3'b100:  cmd_d = C_WR;
        3'b010:  cmd_d = C_PRE;
        3'b001:  cmd_d = C_REF;
        3'b000:  cmd_d = C_MRS;
        default: cmd_d = C_NOP;
      endcase
    end
  end

  // Timers count down in the transient states; reaching 1 ends the wait.
  always_comb begin
    err_d    = E_NONE;
    any_busy = 1'b0;
    sel_st   = B_IDLE;
    open_d   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      if (st_q[i] != B_IDLE) any_busy = 1'b1;
      if (sdr_ba == BA_W'(i)) sel_st = st_q[i];
      if (st_q[i] == B_ACTV || st_q[i] == B_PREC) begin
        if (tmr_q[i] <= TW'(1)) begin
          if (st_q[i] == B_ACTV) st_d[i] = B_OPEN;
          else                   st_d[i] = B_IDLE;
          tmr_d[i] = '0;
        end else begin
          tmr_d[i] = tmr_q[i] - TW'(1);
        end
      end
    end
    case (cmd_d)
      C_ACT: begin
        if (sel_st == B_PREC)      err_d = E_TRP;
        else if (sel_st != B_IDLE) err_d = E_OPEN;
      end
      C_RD, C_WR: begin
        if (sel_st == B_ACTV)      err_d = E_TRCD;
        else if (sel_st != B_OPEN) err_d = E_ACC;
      end
      C_REF: if (any_busy) err_d = E_REF;
      default: ;
    endcase
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (err_d == E_NONE && cmd_d == C_ACT && sdr_ba == BA_W'(i)) begin
        if (T_RCD == 1) begin
          st_d[i]  = B_OPEN;
          tmr_d[i] = '0;
        end else begin
          st_d[i]  = B_ACTV;
          tmr_d[i] = TW'(T_RCD - 1);
        end
      end
      if (cmd_d == C_PRE && (sdr_addr[10] || sdr_ba == BA_W'(i)) &&
          (st_q[i] == B_ACTV || st_q[i] == B_OPEN)) begin
        if (T_RP == 1) begin
          st_d[i]  = B_IDLE;
          tmr_d[i] = '0;
        end else begin
          st_d[i]  = B_PREC;
          tmr_d[i] = TW'(T_RP - 1);
        end
      end
      open_d[i] = (st_d[i] == B_OPEN);
    end
  end

  assign ebank_d = (err_d == E_REF) ? '0 : sdr_ba;

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        st_q[i]  <= B_IDLE;
        tmr_q[i] <= '0;
      end
      cmd_valid <= 1'b0;
      cmd_code  <= C_NOP;
      bank_open <= '0;
      err_valid <= 1'b0;
      err_code  <= E_NONE;
      err_bank  <= '0;
      act_cnt   <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
      end
      cmd_valid <= (cmd_d != C_NOP);
      cmd_code  <= cmd_d;
      bank_open <= open_d;
      err_valid <= (err_d != E_NONE);
      err_code  <= err_d;
      err_bank  <= (err_d != E_NONE) ? ebank_d : '0;
      if (clr_cnt) begin
        act_cnt <= '0;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
      end else begin
        if (cmd_d == C_ACT && act_cnt != '1) act_cnt <= act_cnt + 1'b1;
        if (cmd_d == C_RD  && rd_cnt  != '1) rd_cnt  <= rd_cnt + 1'b1;
        if (cmd_d == C_WR  && wr_cnt  != '1) wr_cnt  <= wr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// Randomized bench for sdr_cmd_monitor against a timestamp-based
// bank model; directed sequences precede the random phase.
module tb_sdr_cmd_monitor;

  localparam int NB    = 4;
  localparam int BA_W  = 2;
  localparam int ROW_W = 13;
  localparam int T_RCD = 3;
  localparam int T_RP  = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam int ACT = 1, RD = 2, WR = 3, PRE = 4, REF = 5, MRS = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cs_n, ras_n, cas_n, we_n;
  logic [BA_W-1:0]  ba;
  logic [ROW_W-1:0] addr;
  logic             clr;
  logic             cmd_valid;
  logic [2:0]       cmd_code;
  logic [NB-1:0]    bank_open;
  logic             err_valid;
  logic [2:0]       err_code;
  logic [BA_W-1:0]  err_bank;
  logic [CNT_W-1:0] act_cnt, rd_cnt, wr_cnt;

  sdr_cmd_monitor #(
    .NUM_BANKS(NB), .BA_W(BA_W), .ROW_W(ROW_W),
    .T_RCD(T_RCD), .T_RP(T_RP), .CNT_W(CNT_W)
  ) dut (
    .sdram_clk(clk), .sdram_resetn(rst_n),
    .sdr_cs_n(cs_n), .sdr_ras_n(ras_n),
    .sdr_cas_n(cas_n), .sdr_we_n(we_n),
    .sdr_ba(ba), .sdr_addr(addr), .clr_cnt(clr),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .bank_open(bank_open), .err_valid(err_valid),
    .err_code(err_code), .err_bank(err_bank),
    .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Model: a bank is either opened or closed since a timestamp (edge no.)
  int edge_n = 0;
  int opened [NB];
  int t_ev   [NB];
  int m_act, m_rd, m_wr;

  // 0 idle, 1 activating, 2 active, 3 precharging at edge e
  function automatic int bst(int b, int e);
    if (opened[b] != 0) return (e - t_ev[b] >= T_RCD) ? 2 : 1;
    return (e - t_ev[b] >= T_RP) ? 0 : 3;
  endfunction

  function automatic int sat(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic step(int c, int b, bit a10, bit cl, bit rst);
    int e_cc, e_ec, e_eb, e_open, s;
    rst_n = !rst;
    clr   = cl;
    ba    = BA_W'(b);
    addr  = ROW_W'($urandom);
    addr[10] = a10;
    cs_n  = 1'b0;
    case (c)
      ACT: {ras_n, cas_n, we_n} = 3'b011;
      RD:  {ras_n, cas_n, we_n} = 3'b101;
      WR:  {ras_n, cas_n, we_n} = 3'b100;
      PRE: {ras_n, cas_n, we_n} = 3'b010;
      REF: {ras_n, cas_n, we_n} = 3'b001;
      MRS: {ras_n, cas_n, we_n} = 3'b000;
      default: begin
        case ($urandom_range(0, 2))
          0: begin
            cs_n = 1'b1;
            {ras_n, cas_n, we_n} = 3'($urandom);
          end
          1: {ras_n, cas_n, we_n} = 3'b111;
          default: {ras_n, cas_n, we_n} = 3'b110;
        endcase
      end
    endcase
    @(posedge clk);
    edge_n++;
    e_cc = 0; e_ec = 0; e_eb = 0;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        opened[i] = 0;
        t_ev[i]   = edge_n - 100;
      end
      m_act = 0; m_rd = 0; m_wr = 0;
    end else begin
      e_cc = (c >= ACT && c <= MRS) ? c : 0;
      s = bst(b, edge_n);
      if (c == ACT) begin
        if (s == 3) e_ec = 4;
        else if (s != 0) e_ec = 1;
      end else if (c == RD || c == WR) begin
        if (s == 1) e_ec = 3;
        else if (s != 2) e_ec = 2;
      end else if (c == REF) begin
        for (int i = 0; i < NB; i++)
          if (bst(i, edge_n) != 0) e_ec = 5;
      end
      if (e_ec != 0 && e_ec != 5) e_eb = b;
      if (e_ec == 0 && c == ACT) begin
        opened[b] = 1;
        t_ev[b]   = edge_n;
      end
      if (c == PRE)
        for (int i = 0; i < NB; i++)
          if ((a10 || i == b) && opened[i] != 0) begin
            opened[i] = 0;
            t_ev[i]   = edge_n;
          end
      if (cl) begin
        m_act = 0; m_rd = 0; m_wr = 0;
      end else begin
        if (c == ACT) m_act = sat(m_act);
        if (c == RD)  m_rd  = sat(m_rd);
        if (c == WR)  m_wr  = sat(m_wr);
      end
    end
    e_open = 0;
    for (int i = 0; i < NB; i++)
      if (bst(i, edge_n + 1) == 2) e_open |= (1 << i);
    #1;
    chk("cmd_valid", int'(cmd_valid), int'(e_cc != 0));
    chk("cmd_code", int'(cmd_code), e_cc);
    chk("err_valid", int'(err_valid), int'(e_ec != 0));
    chk("err_code", int'(err_code), e_ec);
    chk("err_bank", int'(err_bank), e_eb);
    chk("bank_open", int'(bank_open), e_open);
    chk("act_cnt", int'(act_cnt), m_act);
    chk("rd_cnt", int'(rd_cnt), m_rd);
    chk("wr_cnt", int'(wr_cnt), m_wr);
  endtask

  task automatic nops(int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int r, c;
    rst_n = 1'b0; clr = 1'b0; cs_n = 1'b1;
    ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = '0; addr = '0;
    step(0, 0, 0, 0, 1);
    step(ACT, 2, 0, 0, 1);
    // ACT->READ at T_RCD, then early WRITE
    step(ACT, 1, 0, 0, 0); nops(2); step(RD, 1, 0, 0, 0);
    step(ACT, 2, 0, 0, 0); nops(1); step(WR, 2, 0, 0, 0);
    step(PRE, 0, 1, 0, 0); nops(3);
    // precharge-all then ACT inside/after T_RP
    step(ACT, 0, 0, 0, 0); step(ACT, 3, 0, 0, 0); nops(3);
    step(PRE, 0, 1, 0, 0); step(ACT, 0, 0, 0, 0);
    nops(1); step(ACT, 0, 0, 0, 0);
    step(PRE, 0, 1, 0, 0); nops(3);
    // REF with open bank, access to idle bank
    step(ACT, 1, 0, 0, 0); nops(3);
    step(REF, 0, 0, 0, 0); step(RD, 0, 0, 0, 0);
    step(PRE, 0, 1, 0, 0); nops(3);
    // counter saturation and clear-wins
    for (int i = 0; i < 16; i++) begin
      step(ACT, 0, 0, 0, 0); step(PRE, 0, 0, 0, 0); nops(2);
    end
    step(ACT, 0, 0, 1, 0);
    step(PRE, 0, 1, 0, 0); nops(3);
    // reset while activating
    step(ACT, 0, 0, 0, 0); step(0, 0, 0, 0, 1);
    step(RD, 0, 0, 0, 0);
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25) c = ACT;
      else if (r < 38) c = RD;
      else if (r < 51) c = WR;
      else if (r < 68) c = PRE;
      else if (r < 73) c = REF;
      else if (r < 76) c = MRS;
      else c = 0;
      step(c, $urandom_range(0, NB - 1), $urandom_range(0, 3) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 300) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
